mem_arbiter: RTL and testbench

Registered two-requester arbiter between the instruction cache and the data cache. Both caches share the single memory port of `axi_interface`. The arbiter latches the winning request, holds it stable on the memory port until `mem_ready`, and routes the ready pulse and read data back to the winner. It gives the data side priority, with an aging counter that bounds instruction-side starvation.

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter
// Registered I-cache / D-cache arbiter in front of the shared memory port.
// Data side has priority; an aging counter bounds instruction-side starvation.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_strobe,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  input  logic        d_strobe,
  input  logic [31:0] d_addr,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_st_data,
  output logic        d_ready,
  output logic [31:0] rd_data,
  output logic [31:0] mem_a,
  output logic        mem_access,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_st_data,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  output logic        grant_d
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    TURN   = 2'd3
  } state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       aged;
  logic       win_i;
  logic       win_d;

  // The instruction side wins outright when alone, or when it has aged out.
  assign aged  = (wait_cnt == MAX_WAIT_C);
  assign win_i = i_strobe && (!d_strobe || aged);
  assign win_d = d_strobe && !win_i;

  assign i_ready = (state == BUSY_I) && mem_ready;
  assign d_ready = (state == BUSY_D) && mem_ready;
  assign rd_data = mem_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      mem_access  <= 1'b0;
      mem_a       <= 32'd0;
      mem_write   <= 1'b0;
      mem_size    <= 2'd0;
      mem_sel     <= 4'd0;
      mem_st_data <= 32'd0;
      grant_d     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_i) begin
            state       <= BUSY_I;
            mem_access  <= 1'b1;
            mem_a       <= i_addr;
            mem_write   <= 1'b0;
            mem_size    <= 2'b10;
            mem_sel     <= 4'b1111;
            mem_st_data <= 32'd0;
            grant_d     <= 1'b0;
          end else if (win_d) begin
            state       <= BUSY_D;
            mem_access  <= 1'b1;
            mem_a       <= d_addr;
            mem_write   <= d_write;
            mem_size    <= d_size;
            mem_sel     <= d_sel;
            mem_st_data <= d_st_data;
            grant_d     <= 1'b1;
          end
          if (win_i || !i_strobe) begin
            wait_cnt <= 4'd0;
          end else if (win_d && !aged) begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        BUSY_I, BUSY_D: begin
          // Outputs stay frozen until completion, then return to zero for TURN/IDLE.
          if (mem_ready) begin
            state       <= TURN;
            mem_access  <= 1'b0;
            mem_a       <= 32'd0;
            mem_write   <= 1'b0;
            mem_size    <= 2'd0;
            mem_sel     <= 4'd0;
            mem_st_data <= 32'd0;
            grant_d     <= 1'b0;
          end
        end
        TURN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter
// Scoreboard bench: stimulus queues expected completions, a monitor checks them.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_strobe;
  logic [31:0] i_addr;
  logic        i_ready;
  logic        d_strobe;
  logic [31:0] d_addr;
  logic        d_write;
  logic [1:0]  d_size;
  logic [3:0]  d_sel;
  logic [31:0] d_st_data;
  logic        d_ready;
  logic [31:0] rd_data;
  logic [31:0] mem_a;
  logic        mem_access;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic [3:0]  mem_sel;
  logic [31:0] mem_st_data;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic        grant_d;

  logic resp_en;
  logic stray_req;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] a;
    logic        w;
    logic [1:0]  size;
    logic [3:0]  sel;
    logic [31:0] st;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_strobe(i_strobe), .i_addr(i_addr), .i_ready(i_ready),
    .d_strobe(d_strobe), .d_addr(d_addr), .d_write(d_write), .d_size(d_size),
    .d_sel(d_sel), .d_st_data(d_st_data), .d_ready(d_ready),
    .rd_data(rd_data), .mem_a(mem_a), .mem_access(mem_access),
    .mem_write(mem_write), .mem_size(mem_size), .mem_sel(mem_sel),
    .mem_st_data(mem_st_data), .mem_ready(mem_ready), .mem_data(mem_data),
    .grant_d(grant_d)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] resp_data(input logic [31:0] a);
    if (a == 32'hBFC00000) return 32'h3C08BFAF;
    return a ^ 32'hA5A5A5A5;
  endfunction

  function automatic exp_t mk(input logic is_d, input logic [31:0] a, input logic w,
                              input logic [1:0] size, input logic [3:0] sel,
                              input logic [31:0] st, input logic [31:0] rd);
    exp_t e;
    e.is_d = is_d; e.a = a; e.w = w; e.size = size; e.sel = sel; e.st = st; e.rd = rd;
    return e;
  endfunction

  // Memory model: acknowledges 3 cycles after mem_access rises.
  initial begin
    int cnt;
    cnt       = 0;
    mem_ready = 1'b0;
    mem_data  = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ready) begin
        mem_ready = 1'b0;
        cnt = 0;
      end else if (stray_req) begin
        mem_ready = 1'b1;
        mem_data  = 32'h0BADF00D;
        stray_req = 1'b0;
      end else if (reset || !resp_en || !mem_access) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt == 3) begin
          mem_ready = 1'b1;
          mem_data  = resp_data(mem_a);
          cnt = 0;
        end
      end
    end
  end

  // Monitor: every ready pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (i_ready || d_ready) begin
      if (i_ready && d_ready) begin
        check("both_ready", 32'd1, 32'd0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_ready", {30'd0, i_ready, d_ready}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("side_d_ready", {31'd0, d_ready}, {31'd0, e.is_d});
        check("grant_d", {31'd0, grant_d}, {31'd0, e.is_d});
        check("mem_a", mem_a, e.a);
        check("mem_write", {31'd0, mem_write}, {31'd0, e.w});
        check("mem_size", {30'd0, mem_size}, {30'd0, e.size});
        check("mem_sel", {28'd0, mem_sel}, {28'd0, e.sel});
        check("mem_st_data", mem_st_data, e.st);
        check("rd_data", rd_data, e.rd);
      end
    end
  end

  task automatic wait_ready(input int budget);
    int k;
    logic got;
    k = 0;
    got = 1'b0;
    while (!got && k < budget) begin
      @(negedge clk);
      got = i_ready || d_ready;
      k++;
    end
    if (!got) check("wait_ready_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cycles;
    int dcount;

    reset     = 1'b1;
    i_strobe  = 1'b1;
    d_strobe  = 1'b1;
    i_addr    = 32'h00000200;
    d_addr    = 32'h00000100;
    d_write   = 1'b0;
    d_size    = 2'b10;
    d_sel     = 4'hF;
    d_st_data = 32'd0;
    resp_en   = 1'b1;
    stray_req = 1'b0;

    // Reset with both strobes high.
    exp_q.push_back(mk(1'b1, 32'h00000100, 1'b0, 2'b10, 4'hF, 32'd0, 32'hA5A5A4A5));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_access", {31'd0, mem_access}, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_mem_size", {30'd0, mem_size}, 32'd0);
    check("rst_mem_sel", {28'd0, mem_sel}, 32'd0);
    check("rst_mem_st_data", mem_st_data, 32'd0);
    check("rst_grant_d", {31'd0, grant_d}, 32'd0);
    check("rst_ready", {30'd0, i_ready, d_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_access", {31'd0, mem_access}, 32'd1);
    check("post_rst_grant_d", {31'd0, grant_d}, 32'd1);
    wait_ready(20);
    i_strobe = 1'b0;
    d_strobe = 1'b0;
    @(negedge clk);
    check("turn_access_0", {31'd0, mem_access}, 32'd0);

    // Lone instruction fetch.
    repeat (2) @(negedge clk);
    exp_q.push_back(mk(1'b0, 32'hBFC00000, 1'b0, 2'b10, 4'hF, 32'd0, 32'h3C08BFAF));
    i_addr   = 32'hBFC00000;
    i_strobe = 1'b1;
    @(negedge clk);
    check("i_latency_access", {31'd0, mem_access}, 32'd1);
    check("i_latency_addr", mem_a, 32'hBFC00000);
    wait_ready(20);
    i_strobe = 1'b0;
    @(negedge clk);
    check("i_turn_access_0", {31'd0, mem_access}, 32'd0);

    // Data store whose data changes after grant.
    repeat (2) @(negedge clk);
    exp_q.push_back(mk(1'b1, 32'h80001004, 1'b1, 2'b10, 4'h3, 32'h12345678, 32'h25A5B5A1));
    d_addr    = 32'h80001004;
    d_st_data = 32'h12345678;
    d_sel     = 4'h3;
    d_write   = 1'b1;
    d_size    = 2'b10;
    d_strobe  = 1'b1;
    @(negedge clk);
    check("d_grant_access", {31'd0, mem_access}, 32'd1);
    d_st_data = 32'hDEADBEEF;
    @(negedge clk);
    check("d_frozen_st_data", mem_st_data, 32'h12345678);
    wait_ready(20);
    d_strobe = 1'b0;
    dcount = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) check("d_turn_access_0", {31'd0, mem_access}, 32'd0);
      if (d_ready) dcount++;
    end
    check("d_single_pulse", dcount, 32'd0);

    // Contention with aging: expect D,D,D,D,I,D,D,D,D,I.
    repeat (2) @(negedge clk);
    d_addr    = 32'h00000100;
    d_write   = 1'b0;
    d_size    = 2'b10;
    d_sel     = 4'hF;
    d_st_data = 32'd0;
    i_addr    = 32'h00000200;
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 4; j++)
        exp_q.push_back(mk(1'b1, 32'h00000100, 1'b0, 2'b10, 4'hF, 32'd0, 32'hA5A5A4A5));
      exp_q.push_back(mk(1'b0, 32'h00000200, 1'b0, 2'b10, 4'hF, 32'd0, 32'hA5A5A7A5));
    end
    i_strobe = 1'b1;
    d_strobe = 1'b1;
    n = 0;
    cycles = 0;
    while (n < 10 && cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (i_ready || d_ready) n++;
    end
    i_strobe = 1'b0;
    d_strobe = 1'b0;
    check("contention_count", n, 32'd10);

    // Stray mem_ready in IDLE.
    repeat (3) @(negedge clk);
    resp_en   = 1'b0;
    stray_req = 1'b1;
    @(negedge clk);
    check("stray_mem_ready_seen", {31'd0, mem_ready}, 32'd1);
    check("stray_no_ready", {30'd0, i_ready, d_ready}, 32'd0);
    @(negedge clk);

    // Reset during BUSY_I.
    i_addr   = 32'h00000200;
    i_strobe = 1'b1;
    @(negedge clk);
    check("busy_i_access", {31'd0, mem_access}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_access_0", {31'd0, mem_access}, 32'd0);
    check("midrst_no_ready", {31'd0, i_ready}, 32'd0);
    reset    = 1'b0;
    i_strobe = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_idle_access", {31'd0, mem_access}, 32'd0);
    resp_en = 1'b1;

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
